// File: rtl/ct_pkg.sv
// rtl/ct_pkg.sv - shared constants and branch decode for the C&T ROM-address sequencer
package ct_pkg;

  localparam int WORD_LEN = 56;
  localparam int ADR_W    = 8;
  localparam int INST_W   = 10;
  localparam int IA_START = 19;
  localparam int IS_START = 45;
  localparam int CNT_W    = 6;
  localparam int IDX_W    = $clog2(ADR_W);

  localparam logic [1:0]        OP_JSB    = 2'b01;
  localparam logic [1:0]        OP_GOTO   = 2'b11;
  localparam logic [INST_W-1:0] INST_RET  = 10'h030;
  localparam logic [INST_W-1:0] INST_KEYS = 10'h0D0;

  // Bit-time landmarks. The ia register loads one bit time early so that the
  // registered ia lines up with bit_cnt 19..26.
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(WORD_LEN - 1);
  localparam logic [CNT_W-1:0] IA_LOAD_FIRST = CNT_W'(IA_START - 1);
  localparam logic [CNT_W-1:0] IA_LOAD_LAST  = CNT_W'(IA_START + ADR_W - 2);
  localparam logic [CNT_W-1:0] IS_FIRST      = CNT_W'(IS_START);
  localparam logic [CNT_W-1:0] IS_LAST       = CNT_W'(IS_START + INST_W - 1);

  typedef enum logic [2:0] {
    BR_NEXT,
    BR_JSB,
    BR_GOTO,
    BR_RET,
    BR_KEYS
  } br_kind_e;

  // Branch class of a captured instruction; opcode-field matches win over
  // the two full-word matches.
  function automatic br_kind_e decode_branch(input logic [INST_W-1:0] inst);
    br_kind_e kind;
    if (inst[1:0] == OP_JSB)       kind = BR_JSB;
    else if (inst[1:0] == OP_GOTO) kind = BR_GOTO;
    else if (inst == INST_RET)     kind = BR_RET;
    else if (inst == INST_KEYS)    kind = BR_KEYS;
    else                           kind = BR_NEXT;
    return kind;
  endfunction

endpackage

// File: rtl/ct_word_timer.sv
// rtl/ct_word_timer.sv - 56-bit-time word counter, sync marker and window enables
module ct_word_timer
  import ct_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             sync,
  output logic             te_ia,
  output logic [IDX_W-1:0] ia_idx,
  output logic             te_is,
  output logic             te_t55
);

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             sync_q, sync_d;

  // Next bit time and the sync level that goes with it.
  always_comb begin
    bit_cnt_d = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
    sync_d    = (bit_cnt_d != CNT_LAST);
  end

  // Counter and sync registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      sync_q    <= 1'b1;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      sync_q    <= sync_d;
    end
  end

  // Enables for the edge leaving the current bit time.
  always_comb begin
    te_ia  = (bit_cnt_q >= IA_LOAD_FIRST) && (bit_cnt_q <= IA_LOAD_LAST);
    ia_idx = IDX_W'(bit_cnt_q - IA_LOAD_FIRST);
    te_is  = (bit_cnt_q >= IS_FIRST) && (bit_cnt_q <= IS_LAST);
    te_t55 = (bit_cnt_q == CNT_LAST);
  end

  assign bit_cnt = bit_cnt_q;
  assign sync    = sync_q;

endmodule

// File: rtl/ct_rom_addr_seq.sv
// rtl/ct_rom_addr_seq.sv - C&T ROM-address sequencer: pc, return reg, is capture, ia serializer
module ct_rom_addr_seq
  import ct_pkg::*;
(
  input  logic             cph2,
  input  logic             pon,
  input  logic             is,
  input  logic             carry_in,
  input  logic [ADR_W-1:0] key_code,
  output logic             ia,
  output logic             sync,
  output logic [ADR_W-1:0] pc,
  output logic [CNT_W-1:0] bit_cnt
);

  logic             te_ia, te_is, te_t55;
  logic [IDX_W-1:0] ia_idx;

  ct_word_timer u_timer (
    .clk     (cph2),
    .rst     (pon),
    .bit_cnt (bit_cnt),
    .sync    (sync),
    .te_ia   (te_ia),
    .ia_idx  (ia_idx),
    .te_is   (te_is),
    .te_t55  (te_t55)
  );

  logic [ADR_W-1:0]  pc_q, pc_d;
  logic [ADR_W-1:0]  ret_q, ret_d;
  logic [INST_W-1:0] inst_sr_q, inst_sr_d;
  logic              carry_acc_q, carry_acc_d;
  logic              carry_prev_q, carry_prev_d;
  logic              ia_q, ia_d;
  logic [ADR_W-1:0]  pc_inc;

  assign pc_inc = pc_q + ADR_W'(1);

  // Serial capture, carry accumulation, and the end-of-word next-pc decision.
  always_comb begin
    pc_d         = pc_q;
    ret_d        = ret_q;
    inst_sr_d    = inst_sr_q;
    carry_acc_d  = carry_acc_q | carry_in;
    carry_prev_d = carry_prev_q;
    ia_d         = te_ia ? pc_q[ia_idx] : 1'b0;

    if (te_is) begin
      inst_sr_d = {is, inst_sr_q[INST_W-1:1]};
    end

    if (te_t55) begin
      carry_prev_d = carry_acc_q | carry_in;
      carry_acc_d  = 1'b0;
      case (decode_branch(inst_sr_q))
        BR_JSB: begin
          ret_d = pc_inc;
          pc_d  = inst_sr_q[INST_W-1:2];
        end
        BR_GOTO: pc_d = carry_prev_q ? pc_inc : inst_sr_q[INST_W-1:2];
        BR_RET:  pc_d = ret_q;
        BR_KEYS: pc_d = key_code;
        default: pc_d = pc_inc;
      endcase
    end
  end

  // Sequencer state; pon clears everything including a partial capture.
  always_ff @(posedge cph2 or posedge pon) begin
    if (pon) begin
      pc_q         <= '0;
      ret_q        <= '0;
      inst_sr_q    <= '0;
      carry_acc_q  <= 1'b0;
      carry_prev_q <= 1'b0;
      ia_q         <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ret_q        <= ret_d;
      inst_sr_q    <= inst_sr_d;
      carry_acc_q  <= carry_acc_d;
      carry_prev_q <= carry_prev_d;
      ia_q         <= ia_d;
    end
  end

  assign ia = ia_q;
  assign pc = pc_q;

endmodule

// File: tb/tb_ct_rom_addr_seq.sv
// tb/tb_ct_rom_addr_seq.sv - self-checking bench for ct_rom_addr_seq
module tb_ct_rom_addr_seq;

  logic       cph2 = 1'b0;
  logic       pon = 1'b1;
  logic       is_s = 1'b0;
  logic       carry_in = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       ia;
  logic       sync;
  logic [7:0] pc;
  logic [5:0] bit_cnt;

  int checks = 0;
  int errors = 0;

  ct_rom_addr_seq dut (
    .cph2     (cph2),
    .pon      (pon),
    .is       (is_s),
    .carry_in (carry_in),
    .key_code (key_code),
    .ia       (ia),
    .sync     (sync),
    .pc       (pc),
    .bit_cnt  (bit_cnt)
  );

  always #5 cph2 = ~cph2;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level reference: program counter, return register, carry seen in the previous word.
  logic [7:0] m_pc, m_ret;
  logic       m_cprev;

  task automatic model_reset();
    m_pc = 8'h00;
    m_ret = 8'h00;
    m_cprev = 1'b0;
  endtask

  task automatic model_word(input logic [9:0] inst, input logic cword, input logic [7:0] key);
    if (inst[1:0] == 2'b01) begin
      m_ret = m_pc + 8'd1;
      m_pc = inst[9:2];
    end else if (inst[1:0] == 2'b11) begin
      m_pc = m_cprev ? m_pc + 8'd1 : inst[9:2];
    end else if (inst == 10'h030) begin
      m_pc = m_ret;
    end else if (inst == 10'h0D0) begin
      m_pc = key;
    end else begin
      m_pc = m_pc + 8'd1;
    end
    m_cprev = cword;
  endtask

  // Runs one full word starting at the falling edge of bit time 0.
  task automatic run_word(input logic [9:0] inst, input logic [55:0] cbits,
                          input logic [7:0] key, output logic [7:0] ia_seen);
    ia_seen = 8'h00;
    key_code = key;
    for (int b = 0; b < 56; b++) begin
      check("bit_cnt", 32'(bit_cnt), 32'(b));
      check("sync", 32'(sync), 32'(b != 55));
      check("pc_stable", 32'(pc), 32'(m_pc));
      if (b >= 19 && b <= 26) ia_seen[b-19] = ia;
      else check("ia_idle", 32'(ia), 32'd0);
      is_s = (b >= 45 && b <= 54) ? inst[b-45] : 1'($urandom);
      carry_in = cbits[b];
      @(negedge cph2);
    end
    check("ia_window", 32'(ia_seen), 32'(m_pc));
    model_word(inst, |cbits, key);
    check("pc_next", 32'(pc), 32'(m_pc));
  endtask

  typedef struct {
    logic [9:0] inst;
    int         cbit;
    logic [7:0] key;
    logic [7:0] exp_ia;
    logic [7:0] exp_pc;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [7:0]  seen;
    logic [55:0] cb;
    logic [9:0]  inst;
    logic [7:0]  key;
    int          sel;

    tbl[0]  = '{10'h000, -1, 8'h00, 8'h00, 8'h01};
    tbl[1]  = '{10'h000, -1, 8'h00, 8'h01, 8'h02};
    tbl[2]  = '{10'h000, -1, 8'h00, 8'h02, 8'h03};
    tbl[3]  = '{10'h043, -1, 8'h00, 8'h03, 8'h10};
    tbl[4]  = '{10'h169, -1, 8'h00, 8'h10, 8'h5A};
    tbl[5]  = '{10'h030, -1, 8'h00, 8'h5A, 8'h11};
    tbl[6]  = '{10'h000,  7, 8'h00, 8'h11, 8'h12};
    tbl[7]  = '{10'h0CF, -1, 8'h00, 8'h12, 8'h13};
    tbl[8]  = '{10'h0CF, -1, 8'h00, 8'h13, 8'h33};
    tbl[9]  = '{10'h3FF, -1, 8'h00, 8'h33, 8'hFF};
    tbl[10] = '{10'h000, -1, 8'h00, 8'hFF, 8'h00};
    tbl[11] = '{10'h0D0, -1, 8'hA7, 8'h00, 8'hA7};
    tbl[12] = '{10'h000, -1, 8'h5C, 8'hA7, 8'hA8};
    tbl[13] = '{10'h030, -1, 8'h00, 8'hA8, 8'h11};
    tbl[14] = '{10'h081, -1, 8'h00, 8'h11, 8'h20};
    tbl[15] = '{10'h101, -1, 8'h00, 8'h20, 8'h40};
    tbl[16] = '{10'h030, -1, 8'h00, 8'h40, 8'h21};
    tbl[17] = '{10'h000, 55, 8'h00, 8'h21, 8'h22};
    tbl[18] = '{10'h0CF, -1, 8'h00, 8'h22, 8'h23};
    tbl[19] = '{10'h0CF, -1, 8'h00, 8'h23, 8'h33};

    // Reset state.
    repeat (3) @(negedge cph2);
    check("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ia", 32'(ia), 32'd0);
    check("rst_sync", 32'(sync), 32'd1);
    pon = 1'b0;
    model_reset();

    // Directed words with hand-computed results.
    foreach (tbl[i]) begin
      cb = (tbl[i].cbit < 0) ? 56'd0 : (56'd1 << tbl[i].cbit);
      run_word(tbl[i].inst, cb, tbl[i].key, seen);
      check($sformatf("tbl%0d_ia", i), 32'(seen), 32'(tbl[i].exp_ia));
      check($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].exp_pc));
    end

    // pon pulsed at bit 50 while an instruction is half captured and carry is set.
    for (int b = 0; b < 50; b++) begin
      is_s = 1'b1;
      carry_in = 1'b1;
      @(negedge cph2);
    end
    check("mid_bit_cnt", 32'(bit_cnt), 32'd50);
    pon = 1'b1;
    #1;
    check("mid_rst_bit_cnt", 32'(bit_cnt), 32'd0);
    check("mid_rst_pc", 32'(pc), 32'd0);
    check("mid_rst_ia", 32'(ia), 32'd0);
    check("mid_rst_sync", 32'(sync), 32'd1);
    is_s = 1'b0;
    carry_in = 1'b0;
    @(negedge cph2);
    pon = 1'b0;
    model_reset();
    run_word(10'h030, 56'd0, 8'h00, seen);
    check("post_rst_ia", 32'(seen), 32'h00);
    check("post_rst_ret", 32'(pc), 32'h00);
    run_word(10'h0CF, 56'd0, 8'h00, seen);
    check("post_rst_goto", 32'(pc), 32'h33);

    // Randomized words against the reference.
    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 4));
      key = 8'($urandom);
      case (sel)
        0: inst = {8'($urandom), 2'b01};
        1: inst = {8'($urandom), 2'b11};
        2: inst = 10'h030;
        3: inst = 10'h0D0;
        default: inst = 10'($urandom);
      endcase
      cb = ($urandom_range(0, 2) == 0) ? (56'd1 << $urandom_range(0, 55)) : 56'd0;
      run_word(inst, cb, key, seen);
    end
    check("final_pc", 32'(pc), 32'(m_pc));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
